// File: rtl/control_unit_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cpu_pkg
// Purpose  : Shared definitions for the Mini SRC hardwired control sequencer:
//            5-bit opcode map, sequencer state enumeration, instruction class
//            enumeration, packed control word, and the opcode classifier.
// Options  : CTRL_MULDIV_EN - when defined, mul/div are classified as
//            supported multi-cycle ops; otherwise they classify as illegal.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package cpu_pkg;

  // Opcode map (IR[31:27]); the ALU uses the same encoding for its operation.
  localparam logic [4:0] c_OP_LD   = 5'b00000;
  localparam logic [4:0] c_OP_LDI  = 5'b00001;
  localparam logic [4:0] c_OP_ST   = 5'b00010;
  localparam logic [4:0] c_OP_ADD  = 5'b00011;
  localparam logic [4:0] c_OP_SUB  = 5'b00100;
  localparam logic [4:0] c_OP_AND  = 5'b00101;
  localparam logic [4:0] c_OP_OR   = 5'b00110;
  localparam logic [4:0] c_OP_ROR  = 5'b00111;
  localparam logic [4:0] c_OP_ROL  = 5'b01000;
  localparam logic [4:0] c_OP_SHR  = 5'b01001;
  localparam logic [4:0] c_OP_SHRA = 5'b01010;
  localparam logic [4:0] c_OP_SHL  = 5'b01011;
  localparam logic [4:0] c_OP_ADDI = 5'b01100;
  localparam logic [4:0] c_OP_ANDI = 5'b01101;
  localparam logic [4:0] c_OP_ORI  = 5'b01110;
  localparam logic [4:0] c_OP_DIV  = 5'b01111;
  localparam logic [4:0] c_OP_MUL  = 5'b10000;
  localparam logic [4:0] c_OP_NEG  = 5'b10001;
  localparam logic [4:0] c_OP_NOT  = 5'b10010;
  localparam logic [4:0] c_OP_NOP  = 5'b11010;
  localparam logic [4:0] c_OP_HALT = 5'b11011;

  // Sequencer states.
  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_T7     = 4'd8,
    ST_PAUSED = 4'd9,
    ST_HALTED = 4'd10
  } cu_state_t;

  // Instruction classes: opcodes in one class share an identical step sequence.
  typedef enum logic [3:0] {
    CLS_REG     = 4'd0,  // three-register ALU ops
    CLS_UNARY   = 4'd1,  // neg, not
    CLS_IMM     = 4'd2,  // addi, andi, ori
    CLS_LDI     = 4'd3,
    CLS_LD      = 4'd4,
    CLS_ST      = 4'd5,
    CLS_MULDIV  = 4'd6,
    CLS_NOP     = 4'd7,
    CLS_HALT    = 4'd8,
    CLS_ILLEGAL = 4'd9
  } op_class_t;

  // One bit per datapath strobe plus the ALU operation and status flags.
  typedef struct packed {
    logic       PCout;
    logic       PCin;
    logic       IncPC;
    logic       MARin;
    logic       MDRin;
    logic       MDRout;
    logic       Read;
    logic       Write;
    logic       IRin;
    logic       Yin;
    logic       Zlowin;
    logic       Zhighin;
    logic       Zlowout;
    logic       Zhighout;
    logic       LOin;
    logic       HIin;
    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic       Rin;
    logic       Rout;
    logic       BAout;
    logic       Cout;
    logic [4:0] ALU_op;
    logic       Run;
    logic       Illegal;
  } ctrl_word_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t cls;
    case (op)
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_ROR,
      c_OP_ROL, c_OP_SHR, c_OP_SHRA, c_OP_SHL:   cls = CLS_REG;
      c_OP_NEG, c_OP_NOT:                        cls = CLS_UNARY;
      c_OP_ADDI, c_OP_ANDI, c_OP_ORI:            cls = CLS_IMM;
      c_OP_LDI:                                  cls = CLS_LDI;
      c_OP_LD:                                   cls = CLS_LD;
      c_OP_ST:                                   cls = CLS_ST;
`ifdef CTRL_MULDIV_EN
      c_OP_MUL, c_OP_DIV:                        cls = CLS_MULDIV;
`endif
      c_OP_NOP:                                  cls = CLS_NOP;
      c_OP_HALT:                                 cls = CLS_HALT;
      default:                                   cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : control_unit_if
// Purpose  : Bundle between the control sequencer and the single-bus datapath.
// Ports    : IR, Mem_ready, Stop           - datapath/system -> control
//            PC/memory/register strobes,
//            Gra/Grb/Grc/Rin/Rout/BAout/Cout,
//            ALU_op[4:0], Run, Illegal     - control -> datapath
// Modports : master - control unit side; slave - datapath side.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface control_unit_if;
  logic [31:0] IR;
  logic        Mem_ready;
  logic        Stop;

  logic        PCout, PCin, IncPC;
  logic        MARin, MDRin, MDRout, Read, Write;
  logic        IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout;
  logic        LOin, HIin;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic [4:0]  ALU_op;
  logic        Run;
  logic        Illegal;

  modport master (
    input  IR, Mem_ready, Stop,
    output PCout, PCin, IncPC,
    output MARin, MDRin, MDRout, Read, Write,
    output IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout,
    output LOin, HIin,
    output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output ALU_op, Run, Illegal
  );

  modport slave (
    output IR, Mem_ready, Stop,
    input  PCout, PCin, IncPC,
    input  MARin, MDRin, MDRout, Read, Write,
    input  IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout,
    input  LOin, HIin,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    input  ALU_op, Run, Illegal
  );
endinterface
`default_nettype wire

// File: rtl/control_unit_decoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : control_word_decoder
// Purpose  : Combinational Moore map from (sequencer state, opcode) to the
//            full control word. Any strobe not listed for a step stays 0.
// Ports    : i_state  - current sequencer state
//            i_opcode - IR[31:27]; only consulted from T3 onward
//            o_cw     - packed control word
// Options  : CTRL_MULDIV_EN - adds the mul/div T3..T6 step decode.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module control_word_decoder
  import cpu_pkg::*;
(
  input  cu_state_t  i_state,
  input  logic [4:0] i_opcode,
  output ctrl_word_t o_cw
);

  op_class_t w_cls;
  assign w_cls = op_class(i_opcode);

  always_comb begin
    o_cw = '0;
    // Run covers every executing step and the paused state; RST/HALTED keep it low.
    o_cw.Run = (i_state != ST_RST) && (i_state != ST_HALTED);

    case (i_state)
      ST_T0: begin
        o_cw.PCout  = 1'b1;
        o_cw.MARin  = 1'b1;
        o_cw.IncPC  = 1'b1;
        o_cw.Zlowin = 1'b1;
      end
      ST_T1: begin
        o_cw.Zlowout = 1'b1;
        o_cw.PCin    = 1'b1;
        o_cw.Read    = 1'b1;
        o_cw.MDRin   = 1'b1;
      end
      ST_T2: begin
        o_cw.MDRout = 1'b1;
        o_cw.IRin   = 1'b1;
      end
      ST_T3: begin
        case (w_cls)
          CLS_REG, CLS_IMM: begin
            o_cw.Grb  = 1'b1;
            o_cw.Rout = 1'b1;
            o_cw.Yin  = 1'b1;
          end
          // Address-style ops put base (or 0 for R0) on the bus via BAout.
          CLS_LDI, CLS_LD, CLS_ST: begin
            o_cw.Grb   = 1'b1;
            o_cw.BAout = 1'b1;
            o_cw.Yin   = 1'b1;
          end
          CLS_UNARY: begin
            o_cw.Grb    = 1'b1;
            o_cw.Rout   = 1'b1;
            o_cw.ALU_op = i_opcode;
            o_cw.Zlowin = 1'b1;
          end
`ifdef CTRL_MULDIV_EN
          CLS_MULDIV: begin
            o_cw.Gra  = 1'b1;
            o_cw.Rout = 1'b1;
            o_cw.Yin  = 1'b1;
          end
`endif
          CLS_ILLEGAL: o_cw.Illegal = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        case (w_cls)
          CLS_REG: begin
            o_cw.Grc    = 1'b1;
            o_cw.Rout   = 1'b1;
            o_cw.ALU_op = i_opcode;
            o_cw.Zlowin = 1'b1;
          end
          CLS_UNARY: begin
            o_cw.Zlowout = 1'b1;
            o_cw.Gra     = 1'b1;
            o_cw.Rin     = 1'b1;
          end
          CLS_IMM: begin
            o_cw.Cout   = 1'b1;
            o_cw.ALU_op = i_opcode;
            o_cw.Zlowin = 1'b1;
          end
          // Effective address is always base + constant, whatever the opcode.
          CLS_LDI, CLS_LD, CLS_ST: begin
            o_cw.Cout   = 1'b1;
            o_cw.ALU_op = c_OP_ADD;
            o_cw.Zlowin = 1'b1;
          end
`ifdef CTRL_MULDIV_EN
          CLS_MULDIV: begin
            o_cw.Grb     = 1'b1;
            o_cw.Rout    = 1'b1;
            o_cw.ALU_op  = i_opcode;
            o_cw.Zlowin  = 1'b1;
            o_cw.Zhighin = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      ST_T5: begin
        case (w_cls)
          CLS_REG, CLS_IMM, CLS_LDI: begin
            o_cw.Zlowout = 1'b1;
            o_cw.Gra     = 1'b1;
            o_cw.Rin     = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            o_cw.Zlowout = 1'b1;
            o_cw.MARin   = 1'b1;
          end
`ifdef CTRL_MULDIV_EN
          CLS_MULDIV: begin
            o_cw.Zlowout = 1'b1;
            o_cw.LOin    = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      ST_T6: begin
        case (w_cls)
          CLS_LD: begin
            o_cw.Read  = 1'b1;
            o_cw.MDRin = 1'b1;
          end
          // MDR loads from the bus (Read low selects the bus input of MDR).
          CLS_ST: begin
            o_cw.Gra   = 1'b1;
            o_cw.Rout  = 1'b1;
            o_cw.MDRin = 1'b1;
          end
`ifdef CTRL_MULDIV_EN
          CLS_MULDIV: begin
            o_cw.Zhighout = 1'b1;
            o_cw.HIin     = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      ST_T7: begin
        case (w_cls)
          CLS_LD: begin
            o_cw.MDRout = 1'b1;
            o_cw.Gra    = 1'b1;
            o_cw.Rin    = 1'b1;
          end
          CLS_ST:  o_cw.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : control_unit
// Purpose  : Hardwired Mini SRC control sequencer for the single-bus datapath.
//            Holds the step state register and the transition logic; strobes
//            are a Moore decode of the state and IR[31:27].
// Ports    : Clock - rising-edge system clock
//            Reset - asynchronous, active-high; forces RST, all outputs 0
//            bus   - control_unit_if.master (IR, Mem_ready, Stop in;
//                    datapath strobes, ALU_op, Run, Illegal out)
// Options  : CTRL_MULDIV_EN - enables mul/div sequencing (T3..T6).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module control_unit
  import cpu_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  control_unit_if.master   bus
);

  cu_state_t  r_state;
  cu_state_t  w_next_state;
  cu_state_t  w_done_state;
  logic [4:0] w_opcode;
  op_class_t  w_cls;
  ctrl_word_t w_cw;

  assign w_opcode = bus.IR[31:27];
  assign w_cls    = op_class(w_opcode);

  // Where the last step of an instruction goes: Stop is only honoured here.
  assign w_done_state = bus.Stop ? ST_PAUSED : ST_T0;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = ST_RST;
    case (r_state)
      ST_RST: w_next_state = ST_T0;
      ST_T0:  w_next_state = ST_T1;
      ST_T1:  w_next_state = bus.Mem_ready ? ST_T2 : ST_T1;
      ST_T2:  w_next_state = ST_T3;
      ST_T3: begin
        case (w_cls)
          CLS_HALT:             w_next_state = ST_HALTED;
          CLS_NOP, CLS_ILLEGAL: w_next_state = w_done_state;
          default:              w_next_state = ST_T4;
        endcase
      end
      ST_T4: begin
        w_next_state = (w_cls == CLS_UNARY) ? w_done_state : ST_T5;
      end
      ST_T5: begin
        case (w_cls)
          CLS_LD, CLS_ST, CLS_MULDIV: w_next_state = ST_T6;
          default:                    w_next_state = w_done_state;
        endcase
      end
      ST_T6: begin
        case (w_cls)
          CLS_LD:  w_next_state = bus.Mem_ready ? ST_T7 : ST_T6;
          CLS_ST:  w_next_state = ST_T7;
          default: w_next_state = w_done_state;
        endcase
      end
      ST_T7: begin
        // st finishes on its write, which may be stretched by memory.
        if ((w_cls == CLS_ST) && !bus.Mem_ready) begin
          w_next_state = ST_T7;
        end else begin
          w_next_state = w_done_state;
        end
      end
      ST_PAUSED: w_next_state = bus.Stop ? ST_PAUSED : ST_T0;
      ST_HALTED: w_next_state = ST_HALTED;
      default:   w_next_state = ST_RST;
    endcase
  end

  // Output decode
  control_word_decoder u_decoder (
    .i_state  (r_state),
    .i_opcode (w_opcode),
    .o_cw     (w_cw)
  );

  assign bus.PCout    = w_cw.PCout;
  assign bus.PCin     = w_cw.PCin;
  assign bus.IncPC    = w_cw.IncPC;
  assign bus.MARin    = w_cw.MARin;
  assign bus.MDRin    = w_cw.MDRin;
  assign bus.MDRout   = w_cw.MDRout;
  assign bus.Read     = w_cw.Read;
  assign bus.Write    = w_cw.Write;
  assign bus.IRin     = w_cw.IRin;
  assign bus.Yin      = w_cw.Yin;
  assign bus.Zlowin   = w_cw.Zlowin;
  assign bus.Zhighin  = w_cw.Zhighin;
  assign bus.Zlowout  = w_cw.Zlowout;
  assign bus.Zhighout = w_cw.Zhighout;
  assign bus.LOin     = w_cw.LOin;
  assign bus.HIin     = w_cw.HIin;
  assign bus.Gra      = w_cw.Gra;
  assign bus.Grb      = w_cw.Grb;
  assign bus.Grc      = w_cw.Grc;
  assign bus.Rin      = w_cw.Rin;
  assign bus.Rout     = w_cw.Rout;
  assign bus.BAout    = w_cw.BAout;
  assign bus.Cout     = w_cw.Cout;
  assign bus.ALU_op   = w_cw.ALU_op;
  assign bus.Run      = w_cw.Run;
  assign bus.Illegal  = w_cw.Illegal;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_control_unit
// Purpose  : Directed scoreboard bench for control_unit. Each stimulus cycle
//            queues the hand-written expected output word; a monitor on the
//            falling edge pops and compares against the packed DUT outputs.
// Options  : CTRL_MULDIV_EN - selects the mul expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_control_unit;

  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  control_unit_if cu_if ();

  control_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (cu_if)
  );

  // Expected-word bit layout
  localparam logic [31:0] B_PCOUT    = 32'd1 << 0;
  localparam logic [31:0] B_PCIN     = 32'd1 << 1;
  localparam logic [31:0] B_INCPC    = 32'd1 << 2;
  localparam logic [31:0] B_MARIN    = 32'd1 << 3;
  localparam logic [31:0] B_MDRIN    = 32'd1 << 4;
  localparam logic [31:0] B_MDROUT   = 32'd1 << 5;
  localparam logic [31:0] B_READ     = 32'd1 << 6;
  localparam logic [31:0] B_WRITE    = 32'd1 << 7;
  localparam logic [31:0] B_IRIN     = 32'd1 << 8;
  localparam logic [31:0] B_YIN      = 32'd1 << 9;
  localparam logic [31:0] B_ZLOWIN   = 32'd1 << 10;
  localparam logic [31:0] B_ZHIGHIN  = 32'd1 << 11;
  localparam logic [31:0] B_ZLOWOUT  = 32'd1 << 12;
  localparam logic [31:0] B_ZHIGHOUT = 32'd1 << 13;
  localparam logic [31:0] B_LOIN     = 32'd1 << 14;
  localparam logic [31:0] B_HIIN     = 32'd1 << 15;
  localparam logic [31:0] B_GRA      = 32'd1 << 16;
  localparam logic [31:0] B_GRB      = 32'd1 << 17;
  localparam logic [31:0] B_GRC      = 32'd1 << 18;
  localparam logic [31:0] B_RIN      = 32'd1 << 19;
  localparam logic [31:0] B_ROUT     = 32'd1 << 20;
  localparam logic [31:0] B_BAOUT    = 32'd1 << 21;
  localparam logic [31:0] B_COUT     = 32'd1 << 22;
  localparam logic [31:0] B_RUN      = 32'd1 << 23;
  localparam logic [31:0] B_ILLEGAL  = 32'd1 << 24;

  localparam logic [31:0] E_ZERO = 32'd0;
  localparam logic [31:0] E_T0   = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
  localparam logic [31:0] E_T1   = B_RUN | B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [31:0] E_T2   = B_RUN | B_MDROUT | B_IRIN;

  function automatic logic [31:0] alu(input logic [4:0] op);
    return {2'b00, op, 25'd0};
  endfunction

  function automatic logic [31:0] sample_outputs();
    return {2'b00, cu_if.ALU_op, cu_if.Illegal, cu_if.Run, cu_if.Cout,
            cu_if.BAout, cu_if.Rout, cu_if.Rin, cu_if.Grc, cu_if.Grb,
            cu_if.Gra, cu_if.HIin, cu_if.LOin, cu_if.Zhighout,
            cu_if.Zlowout, cu_if.Zhighin, cu_if.Zlowin, cu_if.Yin,
            cu_if.IRin, cu_if.Write, cu_if.Read, cu_if.MDRout,
            cu_if.MDRin, cu_if.MARin, cu_if.IncPC, cu_if.PCin,
            cu_if.PCout};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Monitor: compares whatever the DUT presents this cycle with the queued word.
  always @(negedge Clock) begin : mon
    sb_entry_t   e;
    logic [31:0] act;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      act = sample_outputs();
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.exp, $time);
      end
    end
  end

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input string nm, input logic [31:0] exp);
    sb_entry_t e;
    e.name = nm;
    e.exp  = exp;
    sb.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  // T0, then T1 stretched by t1_waits not-ready cycles, then T2.
  task automatic fetch(input string nm, input int t1_waits);
    cu_if.Mem_ready = 1'b1;
    cyc({nm, "_T0"}, E_T0);
    for (int i = 0; i < t1_waits; i++) begin
      cu_if.Mem_ready = 1'b0;
      cyc({nm, "_T1wait"}, E_T1);
    end
    cu_if.Mem_ready = 1'b1;
    cyc({nm, "_T1"}, E_T1);
    cyc({nm, "_T2"}, E_T2);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    Reset           = 1'b1;
    cu_if.IR        = 32'd0;
    cu_if.Mem_ready = 1'b0;
    cu_if.Stop      = 1'b0;
    @(posedge Clock);
    #1;

    // Reset held, then released: RST persists until the next edge.
    for (int i = 0; i < 3; i++) cyc("reset_held", E_ZERO);
    Reset = 1'b0;
    cyc("reset_release", E_ZERO);

    // add R0,R4,R5
    cu_if.IR = 32'h18228000;
    fetch("add", 0);
    cyc("add_T3", B_RUN | B_GRB | B_ROUT | B_YIN);
    cyc("add_T4", B_RUN | B_GRC | B_ROUT | B_ZLOWIN | alu(5'b00011));
    cyc("add_T5", B_RUN | B_ZLOWOUT | B_GRA | B_RIN);

    // not with three memory wait cycles in T1
    cu_if.IR = {5'b10010, 27'h0450000};
    fetch("not", 3);
    cyc("not_T3", B_RUN | B_GRB | B_ROUT | B_ZLOWIN | alu(5'b10010));
    cyc("not_T4", B_RUN | B_ZLOWOUT | B_GRA | B_RIN);

    // st with two wait cycles on the write
    cu_if.IR = {5'b00010, 27'h0080064};
    fetch("st", 0);
    cyc("st_T3", B_RUN | B_GRB | B_BAOUT | B_YIN);
    cyc("st_T4", B_RUN | B_COUT | B_ZLOWIN | alu(5'b00011));
    cyc("st_T5", B_RUN | B_ZLOWOUT | B_MARIN);
    cyc("st_T6", B_RUN | B_GRA | B_ROUT | B_MDRIN);
    cu_if.Mem_ready = 1'b0;
    cyc("st_T7wait", B_RUN | B_WRITE);
    cyc("st_T7wait", B_RUN | B_WRITE);
    cu_if.Mem_ready = 1'b1;
    cyc("st_T7", B_RUN | B_WRITE);

    // ld with two wait cycles on the read
    cu_if.IR = {5'b00000, 27'h0100055};
    fetch("ld", 0);
    cyc("ld_T3", B_RUN | B_GRB | B_BAOUT | B_YIN);
    cyc("ld_T4", B_RUN | B_COUT | B_ZLOWIN | alu(5'b00011));
    cyc("ld_T5", B_RUN | B_ZLOWOUT | B_MARIN);
    cu_if.Mem_ready = 1'b0;
    cyc("ld_T6wait", B_RUN | B_READ | B_MDRIN);
    cyc("ld_T6wait", B_RUN | B_READ | B_MDRIN);
    cu_if.Mem_ready = 1'b1;
    cyc("ld_T6", B_RUN | B_READ | B_MDRIN);
    cyc("ld_T7", B_RUN | B_MDROUT | B_GRA | B_RIN);

    // nop, then an unsupported opcode (br)
    cu_if.IR = {5'b11010, 27'h0};
    fetch("nop", 0);
    cyc("nop_T3", B_RUN);
    cu_if.IR = {5'b10011, 27'h0};
    fetch("br", 0);
    cyc("br_T3", B_RUN | B_ILLEGAL);

    // add with Stop raised in T4: completes, pauses, resumes
    cu_if.IR = 32'h18228000;
    fetch("add2", 0);
    cyc("add2_T3", B_RUN | B_GRB | B_ROUT | B_YIN);
    cu_if.Stop = 1'b1;
    cyc("add2_T4", B_RUN | B_GRC | B_ROUT | B_ZLOWIN | alu(5'b00011));
    cyc("add2_T5", B_RUN | B_ZLOWOUT | B_GRA | B_RIN);
    cyc("paused", B_RUN);
    cyc("paused", B_RUN);
    cu_if.Stop = 1'b0;
    cyc("paused_exit", B_RUN);

    // halt
    cu_if.IR = {5'b11011, 27'h0};
    fetch("halt", 0);
    cyc("halt_T3", B_RUN);
    cyc("halted", E_ZERO);
    cyc("halted", E_ZERO);

    // Only reset leaves HALTED
    Reset = 1'b1;
    cyc("reset_from_halt", E_ZERO);
    Reset = 1'b0;
    cyc("reset_release2", E_ZERO);

    // mul
    cu_if.IR = {5'b10000, 27'h0120000};
    fetch("mul", 0);
`ifdef CTRL_MULDIV_EN
    cyc("mul_T3", B_RUN | B_GRA | B_ROUT | B_YIN);
    cyc("mul_T4", B_RUN | B_GRB | B_ROUT | B_ZLOWIN | B_ZHIGHIN | alu(5'b10000));
    cyc("mul_T5", B_RUN | B_ZLOWOUT | B_LOIN);
    cyc("mul_T6", B_RUN | B_ZHIGHOUT | B_HIIN);
`else
    cyc("mul_T3", B_RUN | B_ILLEGAL);
`endif

    // Next instruction is aborted by reset in T2
    cu_if.IR = 32'h18228000;
    cyc("post_mul_T0", E_T0);
    cyc("post_mul_T1", E_T1);
    Reset = 1'b1;
    cyc("midinstr_reset", E_ZERO);
    Reset = 1'b0;
    cyc("reset_release3", E_ZERO);
    cyc("restart_T0", E_T0);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
